// File: rtl/draw_rect_phys_ctl.sv
// Purpose: drops a rectangle from the cursor position and bounces it on a floor with damping and optional drift.
// Latency: 1 cycle for cursor follow in IDLE; motion updates one cycle after each physics tick.
// Backpressure: none; outputs are free-running registers with no handshake.
module draw_rect_phys_ctl #(
   parameter int TICK_DIV   = 40_000,
   parameter int GRAVITY    = 1,
   parameter int FLOOR_Y    = 568,
   parameter int DAMP_SHIFT = 2,
   parameter int V_MIN      = 2,
   parameter int V_MAX      = 64,
   parameter int X_SPEED    = 0,
   parameter int X_MAX      = 768
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        moving
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [12:0] GRAV13  = 13'(GRAVITY);
   localparam logic [11:0] GRAV12  = 12'(GRAVITY);
   localparam logic [12:0] FLOOR13 = 13'(FLOOR_Y);
   localparam logic [12:0] VMAX13  = 13'(V_MAX);
   localparam logic [11:0] VMIN12  = 12'(V_MIN);
   localparam logic [12:0] XMAX13  = 13'(X_MAX);
   localparam logic [12:0] XSPD13  = 13'(X_SPEED);

   typedef enum logic [1:0] {IDLE, FALL, RISE, REST} state_t;

   state_t        state, state_n;
   logic [11:0]   v, v_n, x_n, y_n;
   logic          dir, dir_n;          // 1 = moving towards X_MAX
   logic [CW-1:0] tick_cnt, cnt_n;
   logic          ml_d;
   logic          moving_n;
   logic          rise_edge, tick;

   logic [12:0]   v_inc, y_sum, x_fwd;
   logic [11:0]   v_sat, v_damp, x_drift;
   logic          dir_drift;

   assign rise_edge = mouse_left & ~ml_d;
   assign tick      = (tick_cnt == TICK_LAST);

   // Candidate step values; 13-bit sums so ypos+v' and xpos+speed never wrap.
   always_comb begin
      v_inc     = {1'b0, v} + GRAV13;
      v_sat     = (v_inc > VMAX13) ? VMAX13[11:0] : v_inc[11:0];
      y_sum     = {1'b0, ypos} + {1'b0, v_sat};
      v_damp    = v_sat - (v_sat >> DAMP_SHIFT);
      x_fwd     = {1'b0, xpos} + XSPD13;
      x_drift   = xpos;
      dir_drift = dir;
      if (dir) begin
         if (x_fwd >= XMAX13) begin
            x_drift   = XMAX13[11:0];
            dir_drift = 1'b0;
         end else begin
            x_drift = x_fwd[11:0];
         end
      end else begin
         if ({1'b0, xpos} <= XSPD13) begin
            x_drift   = 12'd0;
            dir_drift = 1'b1;
         end else begin
            x_drift = xpos - XSPD13[11:0];
         end
      end
   end

   // Next-state and next-register logic for the follow/fall/rise/rest machine.
   always_comb begin
      state_n = state;
      x_n     = xpos;
      y_n     = ypos;
      v_n     = v;
      dir_n   = dir;
      cnt_n   = tick ? '0 : tick_cnt + 1'b1;
      case (state)
         IDLE: begin
            x_n = mouse_xpos;
            y_n = mouse_ypos;
            if (rise_edge) begin
               // Capture takes priority over a coincident tick.
               v_n     = 12'd0;
               dir_n   = 1'b1;
               cnt_n   = '0;
               state_n = FALL;
            end
         end
         FALL: begin
            if (tick) begin
               if (X_SPEED != 0) begin
                  x_n   = x_drift;
                  dir_n = dir_drift;
               end
               if (y_sum >= FLOOR13) begin
                  y_n = FLOOR13[11:0];
                  if (v_damp >= VMIN12) begin
                     v_n     = v_damp;
                     state_n = RISE;
                  end else begin
                     v_n     = 12'd0;
                     state_n = REST;
                  end
               end else begin
                  y_n = y_sum[11:0];
                  v_n = v_sat;
               end
            end
         end
         RISE: begin
            if (tick) begin
               if (X_SPEED != 0) begin
                  x_n   = x_drift;
                  dir_n = dir_drift;
               end
               if (ypos < v) begin
                  y_n     = 12'd0;
                  v_n     = 12'd0;
                  state_n = FALL;
               end else begin
                  y_n = ypos - v;
                  v_n = (v > GRAV12) ? v - GRAV12 : 12'd0;
                  if (v_n == 12'd0) state_n = FALL;
               end
            end
         end
         REST: begin
            if (rise_edge) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      moving_n = (state_n == FALL) || (state_n == RISE);
   end

   // State and output registers with synchronous reset overriding any motion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         xpos     <= 12'd0;
         ypos     <= 12'd0;
         v        <= 12'd0;
         dir      <= 1'b1;
         tick_cnt <= '0;
         moving   <= 1'b0;
         ml_d     <= 1'b0;
      end else begin
         state    <= state_n;
         xpos     <= x_n;
         ypos     <= y_n;
         v        <= v_n;
         dir      <= dir_n;
         tick_cnt <= cnt_n;
         moving   <= moving_n;
         ml_d     <= mouse_left;
      end
   end

endmodule
